// File: rtl/btn_press_encoder_if.sv
// Press-event bus from the button encoder to a bit-serial consumer.
// The encoder drives every signal; the detector side only listens.
interface btn_press_encoder_if;
    logic o_btn_level;
    logic o_press_pulse;
    logic o_bit_valid;
    logic o_bit;
    logic o_long_pending;

    modport master (
        output o_btn_level,
        output o_press_pulse,
        output o_bit_valid,
        output o_bit,
        output o_long_pending
    );

    modport slave (
        input o_btn_level,
        input o_press_pulse,
        input o_bit_valid,
        input o_bit,
        input o_long_pending
    );
endinterface

// File: rtl/btn_press_encoder.sv
// Button synchroniser, debouncer and short/long press bit encoder.
// One strobed bit per complete press: long hold = 1, short = 0.
module btn_press_encoder #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_btn,
    btn_press_encoder_if.master bus
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO     = '0;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_DEB,
        PRESSED,
        RELEASE_DEB
    } state_t;

    state_t           state, state_n;
    logic             s1, sync;
    logic [CNT_W-1:0] deb_cnt, deb_n;
    logic [CNT_W-1:0] hold_cnt, hold_n, hold_inc;
    logic             level, level_n;
    logic             press_pulse, pp_n;
    logic             bit_valid, bv_n;
    logic             bit_q, bit_n;
    logic             long_pending, lp_n;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            s1           <= 1'b0;
            sync         <= 1'b0;
            state        <= RELEASED;
            deb_cnt      <= ZERO;
            hold_cnt     <= ZERO;
            level        <= 1'b0;
            press_pulse  <= 1'b0;
            bit_valid    <= 1'b0;
            bit_q        <= 1'b0;
            long_pending <= 1'b0;
        end else begin
            s1           <= i_btn;
            sync         <= s1;
            state        <= state_n;
            deb_cnt      <= deb_n;
            hold_cnt     <= hold_n;
            level        <= level_n;
            press_pulse  <= pp_n;
            bit_valid    <= bv_n;
            bit_q        <= bit_n;
            long_pending <= lp_n;
        end
    end

    // Hold count saturates so an arbitrarily long press never wraps to short.
    assign hold_inc = (hold_cnt >= LONG_MAX) ? hold_cnt : hold_cnt + ONE;

    always_comb begin
        state_n = state;
        deb_n   = deb_cnt;
        hold_n  = hold_cnt;
        level_n = level;
        pp_n    = 1'b0;
        bv_n    = 1'b0;
        bit_n   = bit_q;
        unique case (state)
            RELEASED: begin
                if (sync) begin
                    state_n = PRESS_DEB;
                    deb_n   = ONE;
                end
            end
            PRESS_DEB: begin
                if (!sync) begin
                    state_n = RELEASED;
                    deb_n   = ZERO;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n = PRESSED;
                    deb_n   = ZERO;
                    level_n = 1'b1;
                    pp_n    = 1'b1;
                    hold_n  = ZERO;
                end else begin
                    deb_n = deb_cnt + ONE;
                end
            end
            PRESSED: begin
                hold_n = hold_inc;
                if (!sync) begin
                    state_n = RELEASE_DEB;
                    deb_n   = ONE;
                end
            end
            RELEASE_DEB: begin
                hold_n = hold_inc;
                if (sync) begin
                    state_n = PRESSED;
                    deb_n   = ZERO;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n = RELEASED;
                    deb_n   = ZERO;
                    level_n = 1'b0;
                    bv_n    = 1'b1;
                    bit_n   = (hold_cnt >= LONG_MAX);
                    hold_n  = ZERO;
                end else begin
                    deb_n = deb_cnt + ONE;
                end
            end
            default: begin
                state_n = RELEASED;
                deb_n   = ZERO;
                hold_n  = ZERO;
                level_n = 1'b0;
            end
        endcase
        // Registered from next-state values so the LED drops with the strobe.
        lp_n = level_n && (hold_n >= LONG_MAX);
    end

    assign bus.o_btn_level    = level;
    assign bus.o_press_pulse  = press_pulse;
    assign bus.o_bit_valid    = bit_valid;
    assign bus.o_bit          = bit_q;
    assign bus.o_long_pending = long_pending;

endmodule

// File: doc/btn_press_encoder.md
Name: btn_press_encoder

Overview:
Upstream front end for the button-driven sequence detectors; it sits between the raw board button pin and the detector's bit input.
- Synchronises and debounces the raw button.
- Classifies each complete press as short (bit 0) or long (bit 1).
- Emits one single-cycle strobed bit per press, so the user can key a serial pattern such as 1-0-1-0 with one button.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive synchronised samples needed to accept a level change (10 ms at 100 MHz). Must be >= 2.
- LONG_CYCLES, 50_000_000, minimum hold count for a press to encode bit 1 (0.5 s at 100 MHz). Must be > DEBOUNCE_CYCLES.
- CNT_W, 26, width of the debounce and hold counters. Must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
- i_clock, input, 1, system clock; all logic is on the rising edge.
- i_reset, input, 1, synchronous, active-high reset.
- i_btn, input, 1, raw asynchronous button; may bounce.
- o_btn_level, output, 1, debounced button level.
- o_press_pulse, output, 1, one-cycle pulse when a press is accepted.
- o_bit_valid, output, 1, one-cycle strobe when a press completes.
- o_bit, output, 1, encoded bit: 1 = long press, 0 = short press. Valid with o_bit_valid and held until the next strobe.
- o_long_pending, output, 1, high while the button is held and the hold count is >= LONG_CYCLES (user feedback LED).

Behaviour:
- Reset, synchronous on i_clock, active-high on i_reset:
  - Clears both synchroniser flops, both counters, state (to RELEASED) and all outputs to 0.
  - Reset mid-press discards that press; no o_bit_valid is emitted for it.
- Synchroniser: two flops i_btn -> s1 -> sync. All FSM decisions use sync only.
- FSM states: RELEASED, PRESS_DEB, PRESSED, RELEASE_DEB. deb_cnt counts consecutive confirming samples.
  - RELEASED:
    - sync=1 -> PRESS_DEB, deb_cnt=1.
    - sync=0 -> stay.
  - PRESS_DEB:
    - sync=0 -> RELEASED, deb_cnt=0. The bounce is rejected with no output activity.
    - sync=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED, o_btn_level=1, o_press_pulse=1 for one cycle, hold_cnt=0.
    - Otherwise deb_cnt++.
  - PRESSED:
    - hold_cnt increments each cycle and saturates at LONG_CYCLES.
    - sync=0 -> RELEASE_DEB, deb_cnt=1.
  - RELEASE_DEB:
    - hold_cnt keeps incrementing (saturating).
    - sync=1 -> PRESSED, deb_cnt=0. The release bounce is absorbed and the press continues; hold_cnt is not cleared.
    - sync=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> RELEASED, o_btn_level=0, o_bit_valid=1 for one cycle, o_bit=(hold_cnt>=LONG_CYCLES).
    - Otherwise deb_cnt++.
- Latency, for a clean edge: o_btn_level rises on the (DEBOUNCE_CYCLES+2)th rising edge after i_btn rises, together with o_press_pulse. Release behaves symmetrically, with o_bit_valid on the same edge as o_btn_level falling.
- o_long_pending = o_btn_level and hold_cnt>=LONG_CYCLES, registered. It clears on the edge where o_bit_valid is asserted.
- o_press_pulse and o_bit_valid can never assert in the same cycle.
- Hold saturation: hold_cnt never wraps, however long the button is held.
- A press whose hold reaches exactly LONG_CYCLES encodes 1; LONG_CYCLES-1 encodes 0.
- Pulses shorter than DEBOUNCE_CYCLES synchronised samples produce no output at all.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=8):
1. Reset:
   - Stimulus: i_reset=1 for 3 cycles with i_btn=1.
   - Response: all outputs stay 0 throughout reset.
   - After release of reset, o_btn_level rises on the 6th edge.
2. Short press:
   - Stimulus: i_btn high for 10 cycles, then low.
   - Response: o_press_pulse on edge 6; o_bit_valid=1 with o_bit=0 exactly once; o_long_pending never asserts.
3. Long press:
   - Stimulus: i_btn high for 40 cycles.
   - Response: o_long_pending rises 20 cycles after o_press_pulse; at release, o_bit_valid with o_bit=1.
4. Bounce rejection:
   - Stimulus: i_btn toggles 1,0,1,0 with a 1-cycle period for 8 cycles, then low.
   - Response: no o_press_pulse, no o_bit_valid, o_btn_level stays 0.
5. Release bounce:
   - Stimulus: press held 30 cycles, then low 2 cycles, high 1 cycle, low permanently.
   - Response: exactly one o_bit_valid, with o_bit=1.
6. Keying a pattern:
   - Stimulus: long, short, long, short presses with 10 idle cycles between them.
   - Response: four o_bit_valid strobes carrying 1,0,1,0; o_bit holds each value between strobes.
   - Reset mid-press: assert i_reset during the third press; that press yields no strobe.
